ram_ring_ctrl: RTL and testbench

RAM_RING_CTRL -- requirements
Module: ram_ring_ctrl

---
 rtl/ram_ring_ctrl.sv | 138 +++++++++++++
 tb/tb_ram_ring_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ring_ctrl.sv
// Ring-buffer recorder over a single-port RAM: samples stream in while idle, and a
// burst reads the most recent samples back newest-first through a 2-entry skid FIFO.
module ram_ring_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clka,
    input  logic                  rstb,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  burst_start,
    input  logic [ADDR_WIDTH-1:0] burst_len,
    output logic                  burst_busy,
    output logic                  burst_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    localparam logic [ADDR_WIDTH:0]   FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wptr, rptr, rem;
    entry_t                fifo [2];
    entry_t                head;
    logic                  rdp, wrp;
    logic [1:0]            occ, load, limit;
    logic                  rd_inflight, rd_last_q, burst_err_q;
    logic                  wr, rd, pop, push, fifo_pop, start_ok;
    logic [ADDR_WIDTH:0]   fc_post;

    always_comb begin
        wr       = !rstb && state == IDLE && s_valid;
        fc_post  = fill_count + {{ADDR_WIDTH{1'b0}}, (wr && fill_count != FULL)};
        start_ok = burst_len != '0 && {1'b0, burst_len} <= fc_post;

        // With the FIFO empty, the word arriving from the RAM is presented directly so
        // the first sample appears the cycle after its read; otherwise it queues behind.
        if (occ == 2'd0) begin
            head.last = rd_last_q;
            head.data = ram_dout;
        end else begin
            head = fifo[rdp];
        end
        m_valid  = !rstb && (occ != 2'd0 || rd_inflight);
        m_data   = m_valid ? head.data : '0;
        m_last   = m_valid && head.last;
        pop      = m_valid && m_ready;
        fifo_pop = pop && occ != 2'd0;
        push     = rd_inflight && !(pop && occ == 2'd0);

        // Never let buffered + in-flight words exceed the two FIFO slots.
        load  = occ + {1'b0, rd_inflight};
        limit = 2'd2 + {1'b0, pop};
        rd    = !rstb && state == BURST && load < limit;

        ram_en   = wr || rd;
        ram_we   = wr;
        ram_addr = wr ? wptr : (rd ? rptr : '0);
        ram_din  = wr ? s_data : '0;

        s_ready    = !rstb && state == IDLE;
        burst_busy = state != IDLE;
        burst_err  = burst_err_q && !rstb;
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            rem         <= '0;
            fill_count  <= '0;
            occ         <= '0;
            rdp         <= 1'b0;
            wrp         <= 1'b0;
            rd_inflight <= 1'b0;
            rd_last_q   <= 1'b0;
            burst_err_q <= 1'b0;
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + ONE;
                if (fill_count != FULL) fill_count <= fill_count + 1'b1;
            end

            rd_inflight <= rd;
            rd_last_q   <= rd && rem == ONE;
            if (push) begin
                fifo[wrp].last <= rd_last_q;
                fifo[wrp].data <= ram_dout;
                wrp            <= ~wrp;
            end
            if (fifo_pop) rdp <= ~rdp;
            occ <= occ + {1'b0, push} - {1'b0, fifo_pop};

            burst_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (burst_start) begin
                        if (start_ok) begin
                            state <= BURST;
                            rptr  <= wr ? wptr : wptr - ONE;
                            rem   <= burst_len;
                        end else begin
                            burst_err_q <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (rd) begin
                        rptr <= rptr - ONE;
                        rem  <= rem - ONE;
                        if (rem == ONE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && m_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_ring_ctrl.sv
// Bench for ram_ring_ctrl: a RAM model behind the DUT and a history queue of every
// written sample as the reference; bursts must return the newest samples in reverse order.
module tb_ram_ring_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clka = 1'b0;
    logic          rstb = 1'b1;
    logic          s_valid = 1'b0, s_ready;
    logic [DW-1:0] s_data = '0;
    logic          burst_start = 1'b0;
    logic [AW-1:0] burst_len = '0;
    logic          burst_busy, burst_err, m_valid, m_last;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW:0]   fill_count;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] mem [16];

    always #5 clka = ~clka;

    ram_ring_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clka(clka), .rstb(rstb), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .burst_start(burst_start), .burst_len(burst_len), .burst_busy(burst_busy),
        .burst_err(burst_err), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .fill_count(fill_count), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM, 1-cycle read latency, dout unchanged on writes.
    always @(posedge clka) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    int            checks = 0, errors = 0;
    logic [DW-1:0] hist [$];
    logic [DW-1:0] got_d [$];
    bit            got_l [$];
    logic [AW-1:0] got_a [$];
    int            first_vld, stall_chg, err_cnt, busy_cnt;
    bit            timed_out;

    function automatic int mfill();
        return (hist.size() > 16) ? 16 : hist.size();
    endfunction

    function automatic logic [DW-1:0] newest(input int k);
        return hist[hist.size() - 1 - k];
    endfunction

    task automatic write_n(input int n, input bit seq, input int start);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            @(negedge clka);
            v = seq ? DW'(start + i) : $urandom;
            s_valid = 1'b1;
            s_data  = v;
            hist.push_back(v);
        end
        @(negedge clka);
        s_valid = 1'b0;
    endtask

    // Drives one burst request and records what comes back; comparisons live in the tests.
    task automatic do_burst(input int len, input int mode, input bit wr_en, input logic [DW-1:0] wd);
        bit            r, prev_stall;
        logic [DW-1:0] prev_d;
        got_d.delete(); got_l.delete(); got_a.delete();
        first_vld = -1; stall_chg = 0; err_cnt = 0; busy_cnt = 0; timed_out = 1'b1;
        prev_stall = 1'b0; prev_d = '0;
        @(negedge clka);
        burst_start = 1'b1;
        burst_len   = AW'(len);
        s_valid     = wr_en;
        s_data      = wd;
        if (wr_en) hist.push_back(wd);
        for (int n = 1; n <= 400; n++) begin
            @(negedge clka);
            s_valid     = 1'b0;
            burst_start = (mode == 1 && n == 3);
            burst_len   = '0;
            case (mode)
                0:       r = 1'b1;
                1:       r = ((n - 1) % 4 == 0) || ((n - 1) % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            m_ready = r;
            #1;
            if (burst_err) err_cnt++;
            if (burst_busy) busy_cnt++;
            if (ram_en && !ram_we) got_a.push_back(ram_addr);
            if (m_valid && first_vld < 0) first_vld = n;
            if (prev_stall && m_data !== prev_d) stall_chg++;
            prev_stall = m_valid && !r;
            prev_d     = m_data;
            if (m_valid && r) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
                if (m_last) begin timed_out = 1'b0; break; end
            end
            if (n >= 3 && !burst_busy && !m_valid) begin timed_out = 1'b0; break; end
        end
        @(negedge clka);
        burst_start = 1'b0;
        m_ready     = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b1; s_valid = 1'b1; s_data = 32'h5;
        repeat (2) @(negedge clka);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
        checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
            errors++; $display("FAIL reset_ram got en=%b we=%b addr=%0d din=%h exp all 0", ram_en, ram_we, ram_addr, ram_din); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0) begin
            errors++; $display("FAIL reset_m got v=%b l=%b d=%h exp 0", m_valid, m_last, m_data); end
        checks++; if (fill_count !== '0 || burst_busy !== 1'b0 || burst_err !== 1'b0) begin
            errors++; $display("FAIL reset_state got fill=%0d busy=%b err=%b exp 0", fill_count, burst_busy, burst_err); end
        s_valid = 1'b0; rstb = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready got %b exp 1", s_ready); end
        hist.delete();
    endtask

    task automatic test_basic();
        hist.push_back(32'h11); hist.push_back(32'h22); hist.push_back(32'h33);
        foreach (hist[i]) begin @(negedge clka); s_valid = 1'b1; s_data = hist[i]; end
        @(negedge clka); s_valid = 1'b0; #1;
        checks++; if (fill_count !== 5'd3) begin errors++; $display("FAIL basic_fill got %0d exp 3", fill_count); end
        do_burst(3, 0, 1'b0, '0);
        checks++; if (timed_out || got_d.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3 (timeout=%b)", got_d.size(), timed_out); end
        checks++; if (first_vld != 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", first_vld); end
        for (int k = 0; k < got_d.size() && k < 3; k++) begin
            checks++; if (got_d[k] !== newest(k) || got_l[k] !== (k == 2)) begin
                errors++; $display("FAIL basic_data[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], newest(k), k == 2); end
        end
    endtask

    task automatic test_wrap();
        rstb = 1'b1; @(negedge clka); rstb = 1'b0; hist.delete();
        write_n(20, 1'b1, 1);
        #1;
        checks++; if (fill_count !== 5'd16) begin errors++; $display("FAIL wrap_fill got %0d exp 16", fill_count); end
        do_burst(15, 0, 1'b0, '0);
        checks++; if (timed_out || got_d.size() != 15 || got_a.size() != 15) begin
            errors++; $display("FAIL wrap_count got %0d data %0d reads exp 15", got_d.size(), got_a.size()); end
        for (int k = 0; k < got_d.size() && k < 15; k++) begin
            checks++; if (got_d[k] !== DW'(20 - k) || got_l[k] !== (k == 14)) begin
                errors++; $display("FAIL wrap_data[%0d] got %0d/%b exp %0d/%b", k, got_d[k], got_l[k], 20 - k, k == 14); end
        end
        for (int k = 0; k < got_a.size() && k < 15; k++) begin
            checks++; if (got_a[k] !== AW'(19 - k)) begin
                errors++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", k, got_a[k], AW'(19 - k)); end
        end
    endtask

    task automatic test_err();
        rstb = 1'b1; @(negedge clka); rstb = 1'b0; hist.delete();
        write_n(3, 1'b0, 0);
        do_burst(4, 0, 1'b0, '0);
        checks++; if (err_cnt != 1 || busy_cnt != 0 || got_d.size() != 0) begin
            errors++; $display("FAIL err_toolong got err=%0d busy=%0d out=%0d exp 1/0/0", err_cnt, busy_cnt, got_d.size()); end
        do_burst(0, 0, 1'b0, '0);
        checks++; if (err_cnt != 1 || busy_cnt != 0 || got_d.size() != 0) begin
            errors++; $display("FAIL err_zero got err=%0d busy=%0d out=%0d exp 1/0/0", err_cnt, busy_cnt, got_d.size()); end
        #1;
        checks++; if (fill_count !== 5'd3) begin errors++; $display("FAIL err_fill got %0d exp 3", fill_count); end
    endtask

    task automatic test_stall();
        write_n(10, 1'b0, 0);
        do_burst(8, 1, 1'b0, '0);
        checks++; if (timed_out || got_d.size() != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", got_d.size()); end
        checks++; if (stall_chg != 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", stall_chg); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL stall_ignore_start got %0d err pulses exp 0", err_cnt); end
        for (int k = 0; k < got_d.size() && k < 8; k++) begin
            checks++; if (got_d[k] !== newest(k) || got_l[k] !== (k == 7)) begin
                errors++; $display("FAIL stall_data[%0d] got %h/%b exp %h/%b", k, got_d[k], got_l[k], newest(k), k == 7); end
        end
    endtask

    task automatic test_same_cycle();
        do_burst(1, 0, 1'b1, 32'hAA);
        checks++; if (timed_out || got_d.size() != 1) begin errors++; $display("FAIL same_count got %0d exp 1", got_d.size()); end
        else begin
            checks++; if (got_d[0] !== 32'hAA || got_l[0] !== 1'b1) begin
                errors++; $display("FAIL same_data got %h/%b exp aa/1", got_d[0], got_l[0]); end
        end
        #1;
        checks++; if (fill_count !== 5'(mfill())) begin errors++; $display("FAIL same_fill got %0d exp %0d", fill_count, mfill()); end
    endtask

    task automatic test_reset_mid();
        int acc, vcnt;
        write_n(8, 1'b0, 0);
        @(negedge clka);
        burst_start = 1'b1; burst_len = 4'd8;
        acc = 0;
        for (int n = 0; n < 50 && acc < 2; n++) begin
            @(negedge clka); burst_start = 1'b0; m_ready = 1'b1; #1;
            if (m_valid) acc++;
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL mid_before got %0d samples exp 2", acc); end
        rstb = 1'b1;
        @(negedge clka); #1;
        checks++; if (m_valid !== 1'b0 || fill_count !== '0 || burst_busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%b fill=%0d busy=%b rdy=%b exp 0/0/0/0", m_valid, fill_count, burst_busy, s_ready); end
        rstb = 1'b0; #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready got %b exp 1", s_ready); end
        vcnt = 0;
        repeat (6) begin @(negedge clka); #1; if (m_valid) vcnt++; end
        checks++; if (vcnt != 0) begin errors++; $display("FAIL mid_no_valid got %0d valid cycles exp 0", vcnt); end
        m_ready = 1'b0;
        hist.delete();
    endtask

    task automatic test_random();
        int len;
        bit ok;
        for (int it = 0; it < 10; it++) begin
            write_n($urandom_range(0, 12), 1'b0, 0);
            len = $urandom_range(0, 15);
            ok  = (len >= 1) && (len <= mfill());
            do_burst(len, 2, 1'b0, '0);
            if (ok) begin
                checks++; if (timed_out || got_d.size() != len || err_cnt != 0) begin
                    errors++; $display("FAIL rand_count[%0d] got %0d err=%0d exp %0d", it, got_d.size(), err_cnt, len); end
                checks++; if (stall_chg != 0) begin errors++; $display("FAIL rand_hold[%0d] got %0d changes exp 0", it, stall_chg); end
                for (int k = 0; k < got_d.size() && k < len; k++) begin
                    checks++; if (got_d[k] !== newest(k) || got_l[k] !== (k == len - 1)) begin
                        errors++; $display("FAIL rand_data[%0d][%0d] got %h/%b exp %h/%b", it, k, got_d[k], got_l[k], newest(k), k == len - 1); end
                end
            end else begin
                checks++; if (err_cnt != 1 || got_d.size() != 0) begin
                    errors++; $display("FAIL rand_err[%0d] got err=%0d out=%0d exp 1/0", it, err_cnt, got_d.size()); end
            end
            #1;
            checks++; if (fill_count !== 5'(mfill())) begin errors++; $display("FAIL rand_fill[%0d] got %0d exp %0d", it, fill_count, mfill()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_err();
        test_stall();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
